// File: rtl/bju_issue_ctrl.sv
// In-order issue controller for the branch/jump unit: small op FIFO, one
// registered execute stage, link writeback and a held redirect to the frontend.
module bju_issue_ctrl #(
  parameter int DEPTH     = 4,
  parameter int ROB_IDX_W = 6,
  parameter int SRC_W     = 64,
  parameter int PC_W      = 48,
  parameter int CX_W      = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush_valid,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [SRC_W-1:0]     enq_src1,
  input  logic [SRC_W-1:0]     enq_src2,
  input  logic [SRC_W-1:0]     enq_imm,
  input  logic [PC_W-1:0]      enq_pc,
  input  logic [CX_W-1:0]      enq_cx_type,
  input  logic                 enq_is_unsigned,
  input  logic [ROB_IDX_W-1:0] enq_robidx,
  output logic                 bju_valid,
  output logic [SRC_W-1:0]     bju_src1,
  output logic [SRC_W-1:0]     bju_src2,
  output logic [SRC_W-1:0]     bju_imm,
  output logic [PC_W-1:0]      bju_pc,
  output logic [CX_W-1:0]      bju_cx_type,
  output logic                 bju_is_unsigned,
  input  logic [SRC_W-1:0]     bju_dest,
  input  logic                 bju_redirect_valid,
  input  logic [PC_W-1:0]      bju_redirect_target,
  output logic                 wb_valid,
  output logic [SRC_W-1:0]     wb_dest,
  output logic [ROB_IDX_W-1:0] wb_robidx,
  output logic                 redir_valid,
  output logic [PC_W-1:0]      redir_target,
  output logic [ROB_IDX_W-1:0] redir_robidx,
  input  logic                 redir_ready
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [SRC_W-1:0]     src1;
    logic [SRC_W-1:0]     src2;
    logic [SRC_W-1:0]     imm;
    logic [PC_W-1:0]      pc;
    logic [CX_W-1:0]      cx;
    logic                 uns;
    logic [ROB_IDX_W-1:0] rob;
  } uop_t;

  typedef enum logic {RUN, REDIR_WAIT} state_e;

  state_e               state_q, state_d;
  uop_t                 mem_q [DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  uop_t                 ex_q;
  logic                 ex_vld_q;
  logic                 wb_vld_q;
  logic [SRC_W-1:0]     wb_dest_q;
  logic [ROB_IDX_W-1:0] wb_rob_q;
  logic [PC_W-1:0]      rtgt_q;
  logic [ROB_IDX_W-1:0] rrob_q;

  logic empty, full, redir_det, issue, enq_fire;
  uop_t enq_op;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign redir_det = ex_vld_q & bju_redirect_valid;
  assign enq_fire  = enq_valid & enq_ready;
  assign enq_op    = '{src1: enq_src1, src2: enq_src2, imm: enq_imm, pc: enq_pc,
                       cx: enq_cx_type, uns: enq_is_unsigned, rob: enq_robidx};

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // FSM: next state; flush wins over everything
  always_comb begin
    state_d = state_q;
    if (flush_valid) state_d = RUN;
    else begin
      case (state_q)
        RUN:        if (redir_det)   state_d = REDIR_WAIT;
        REDIR_WAIT: if (redir_ready) state_d = RUN;
        default:    state_d = RUN;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    enq_ready   = (state_q == RUN) & ~full & ~flush_valid;
    redir_valid = (state_q == REDIR_WAIT);
    issue       = (state_q == RUN) & ~empty & ~redir_det & ~flush_valid;
  end

  // Everything left in the FIFO is younger than a redirecting op, so a
  // redirect empties it outright (including any op enqueued this cycle).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_valid | redir_det) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (enq_fire) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (issue)    rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire) mem_q[wr_ptr_q[AW-1:0]] <= enq_op;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_vld_q <= 1'b0;
      ex_q     <= '0;
    end else begin
      ex_vld_q <= issue;
      if (issue) ex_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // BJU is combinational: the ex op always completes, and writes back unless flushed.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_vld_q  <= 1'b0;
      wb_dest_q <= '0;
      wb_rob_q  <= '0;
    end else begin
      wb_vld_q <= ex_vld_q & ~flush_valid;
      if (ex_vld_q) begin
        wb_dest_q <= bju_dest;
        wb_rob_q  <= ex_q.rob;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rtgt_q <= '0;
      rrob_q <= '0;
    end else if ((state_q == RUN) & redir_det & ~flush_valid) begin
      rtgt_q <= bju_redirect_target;
      rrob_q <= ex_q.rob;
    end
  end

  assign bju_valid       = ex_vld_q;
  assign bju_src1        = ex_q.src1;
  assign bju_src2        = ex_q.src2;
  assign bju_imm         = ex_q.imm;
  assign bju_pc          = ex_q.pc;
  assign bju_cx_type     = ex_q.cx;
  assign bju_is_unsigned = ex_q.uns;
  assign wb_valid        = wb_vld_q;
  assign wb_dest         = wb_dest_q;
  assign wb_robidx       = wb_rob_q;
  assign redir_target    = rtgt_q;
  assign redir_robidx    = rrob_q;

endmodule

// File: tb/tb_bju_issue_ctrl.sv
// Randomized bench for bju_issue_ctrl: the bench plays the BJU and tracks the
// expected behaviour with a queue-based reference model.
module tb_bju_issue_ctrl;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n, flush_valid, enq_valid, enq_ready, enq_is_unsigned;
  logic [63:0] enq_src1, enq_src2, enq_imm;
  logic [47:0] enq_pc;
  logic [5:0]  enq_cx_type, enq_robidx;
  logic        bju_valid, bju_is_unsigned;
  logic [63:0] bju_src1, bju_src2, bju_imm, bju_dest;
  logic [47:0] bju_pc, bju_redirect_target;
  logic [5:0]  bju_cx_type;
  logic        bju_redirect_valid;
  logic        wb_valid, redir_valid, redir_ready;
  logic [63:0] wb_dest;
  logic [5:0]  wb_robidx, redir_robidx;
  logic [47:0] redir_target;

  always #5 clock = ~clock;

  bju_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .flush_valid(flush_valid),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_src1(enq_src1), .enq_src2(enq_src2), .enq_imm(enq_imm), .enq_pc(enq_pc),
    .enq_cx_type(enq_cx_type), .enq_is_unsigned(enq_is_unsigned), .enq_robidx(enq_robidx),
    .bju_valid(bju_valid), .bju_src1(bju_src1), .bju_src2(bju_src2), .bju_imm(bju_imm),
    .bju_pc(bju_pc), .bju_cx_type(bju_cx_type), .bju_is_unsigned(bju_is_unsigned),
    .bju_dest(bju_dest), .bju_redirect_valid(bju_redirect_valid),
    .bju_redirect_target(bju_redirect_target),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_robidx(wb_robidx),
    .redir_valid(redir_valid), .redir_target(redir_target), .redir_robidx(redir_robidx),
    .redir_ready(redir_ready)
  );

  typedef struct {
    logic [63:0] s1, s2, imm;
    logic [47:0] pc;
    logic [5:0]  cx;
    logic        uns;
    logic [5:0]  tag;
  } op_t;

  // Architectural branch/jump semantics
  function automatic void bju_eval(input op_t o, output bit tk, output logic [47:0] tg);
    tg = o.pc + o.imm[47:0];
    tk = 1'b0;
    if      (o.cx[0]) tk = 1'b1;
    else if (o.cx[1]) begin tk = 1'b1; tg = (o.s1[47:0] + o.imm[47:0]) & ~48'h1; end
    else if (o.cx[2]) tk = (o.s1 == o.s2);
    else if (o.cx[3]) tk = (o.s1 != o.s2);
    else if (o.cx[4]) tk = o.uns ? (o.s1 < o.s2) : ($signed(o.s1) < $signed(o.s2));
    else if (o.cx[5]) tk = o.uns ? (o.s1 >= o.s2) : ($signed(o.s1) >= $signed(o.s2));
  endfunction

  // The bench acts as the combinational BJU on the DUT's execute-stage outputs
  always_comb begin
    op_t  cur;
    bit   tk;
    logic [47:0] tg;
    cur = '{s1: bju_src1, s2: bju_src2, imm: bju_imm, pc: bju_pc,
            cx: bju_cx_type, uns: bju_is_unsigned, tag: 6'd0};
    bju_eval(cur, tk, tg);
    bju_dest            = 64'(bju_pc) + 64'd4;
    bju_redirect_valid  = tk;
    bju_redirect_target = tg;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  op_t         q[$];
  op_t         ex_op;
  bit          ex_v, wb_v, rw;
  logic [63:0] wb_d;
  logic [5:0]  wb_t, r_tag;
  logic [47:0] r_tgt;

  // One clock: drive at negedge, advance model, check at next negedge
  task automatic step(input bit ev, input op_t o, input bit fl, input bit rr, input bit rst);
    bit acc, tk;
    logic [47:0] tg;
    enq_valid = ev; enq_src1 = o.s1; enq_src2 = o.s2; enq_imm = o.imm; enq_pc = o.pc;
    enq_cx_type = o.cx; enq_is_unsigned = o.uns; enq_robidx = o.tag;
    flush_valid = fl; redir_ready = rr; reset_n = !rst;
    #1;
    if (!rst) chk("enq_ready", 64'(enq_ready), 64'(!rw && q.size() < DEPTH && !fl));
    acc = ev && !rw && q.size() < DEPTH && !fl;
    tk = 1'b0; tg = '0;
    if (ex_v) bju_eval(ex_op, tk, tg);
    if (rst) begin
      q.delete(); ex_v = 0; wb_v = 0; rw = 0;
    end else if (fl) begin
      q.delete(); ex_v = 0; wb_v = 0; rw = 0;
    end else begin
      wb_v = ex_v;
      if (ex_v) begin wb_d = 64'(ex_op.pc) + 64'd4; wb_t = ex_op.tag; end
      if (rw) begin
        if (rr) rw = 0;
        ex_v = 0;
      end else if (tk) begin
        rw = 1; r_tgt = tg; r_tag = ex_op.tag; q.delete(); ex_v = 0;
      end else begin
        ex_v = (q.size() > 0);
        if (ex_v) ex_op = q.pop_front();
        if (acc) q.push_back(o);
      end
    end
    @(posedge clock);
    @(negedge clock);
    chk("bju_valid", 64'(bju_valid), 64'(ex_v));
    if (ex_v) begin
      chk("bju_pc",   64'(bju_pc), 64'(ex_op.pc));
      chk("bju_src1", bju_src1, ex_op.s1);
      chk("bju_src2", bju_src2, ex_op.s2);
      chk("bju_imm",  bju_imm, ex_op.imm);
      chk("bju_cx",   64'({bju_is_unsigned, bju_cx_type}), 64'({ex_op.uns, ex_op.cx}));
    end
    chk("wb_valid", 64'(wb_valid), 64'(wb_v));
    if (wb_v) begin
      chk("wb_dest",   wb_dest, wb_d);
      chk("wb_robidx", 64'(wb_robidx), 64'(wb_t));
    end
    chk("redir_valid", 64'(redir_valid), 64'(rw));
    if (rw) begin
      chk("redir_target", 64'(redir_target), 64'(r_tgt));
      chk("redir_robidx", 64'(redir_robidx), 64'(r_tag));
    end
  endtask

  function automatic op_t mk(input logic [5:0] cx, input logic [63:0] s1, input logic [63:0] s2,
                             input logic [47:0] pc, input logic [63:0] imm, input logic [5:0] tag);
    op_t o;
    o = '{s1: s1, s2: s2, imm: imm, pc: pc, cx: cx, uns: 1'b0, tag: tag};
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    logic [1:0] a, b;
    int sel;
    a = 2'($urandom); b = 2'($urandom);
    sel = $urandom_range(0, 9);
    o.s1  = {{62{a[1]}}, a};
    o.s2  = {{62{b[1]}}, b};
    o.imm = 64'($urandom_range(0, 255)) << 2;
    o.pc  = 48'($urandom_range(0, 16'hffff)) << 2;
    o.cx  = (sel < 6) ? 6'(1 << sel) : 6'b000100;
    o.uns = 1'($urandom);
    o.tag = 6'($urandom);
    return o;
  endfunction

  initial begin
    op_t nop, beq1;
    nop = mk(6'd0, 0, 0, 0, 0, 0);
    reset_n = 1'b0; flush_valid = 0; enq_valid = 0; redir_ready = 0;
    enq_src1 = 0; enq_src2 = 0; enq_imm = 0; enq_pc = 0; enq_cx_type = 0;
    enq_is_unsigned = 0; enq_robidx = 0;
    q.delete(); ex_v = 0; wb_v = 0; rw = 0; wb_d = 0; wb_t = 0; r_tgt = 0; r_tag = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_bju_valid", 64'(bju_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_redir_valid", 64'(redir_valid), 64'd0);
    chk("rst_bju_pc", 64'(bju_pc), 64'd0);
    chk("rst_wb_dest", wb_dest, 64'd0);
    chk("rst_redir_target", 64'(redir_target), 64'd0);
    reset_n = 1'b1; #1;
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);

    // three not-taken BEQs back to back, then drain
    for (int i = 1; i <= 3; i++) step(1, mk(6'b000100, 1, 2, 48'h200 + 48'(4*i), 64'h40, 6'(i)), 0, 0, 0);
    repeat (3) step(0, nop, 0, 0, 0);

    // JAL with two younger ops behind it; frontend stalls the redirect 5 cycles
    step(1, mk(6'b000001, 0, 0, 48'h1000, 64'h20, 6'd10), 0, 0, 0);
    step(1, mk(6'b000100, 1, 2, 48'h1004, 64'h8, 6'd11), 0, 0, 0);
    step(1, mk(6'b000100, 1, 2, 48'h1008, 64'h8, 6'd12), 0, 0, 0);
    repeat (5) step(1, mk(6'b000100, 1, 2, 48'h100c, 64'h8, 6'd13), 0, 0, 0);
    step(0, nop, 0, 1, 0);
    beq1 = mk(6'b000100, 1, 2, 48'h2000, 64'h8, 6'd14);
    step(1, beq1, 0, 0, 0);
    repeat (3) step(0, nop, 0, 0, 0);

    // flush while a redirect is pending
    step(1, mk(6'b000001, 0, 0, 48'h3000, 64'h100, 6'd20), 0, 0, 0);
    step(1, mk(6'b000100, 1, 2, 48'h3004, 64'h8, 6'd21), 0, 0, 0);
    step(1, mk(6'b000100, 1, 2, 48'h3008, 64'h8, 6'd22), 0, 0, 0);
    step(0, nop, 0, 0, 0);
    step(1, beq1, 1, 0, 0);
    repeat (3) step(0, nop, 0, 0, 0);

    // reset while an op sits in execute
    step(1, beq1, 0, 0, 0);
    step(1, mk(6'b000100, 1, 2, 48'h2004, 64'h8, 6'd15), 0, 0, 0);
    step(0, nop, 0, 0, 1);
    repeat (2) step(0, nop, 0, 0, 0);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rnd_op(), $urandom_range(0, 29) == 0,
           1'($urandom), (i % 500) == 499);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bju_issue_ctrl.md
Name: bju_issue_ctrl

Overview:
In-order issue controller for the single branch/jump unit. Buffers branch/jump micro-ops from dispatch in a small FIFO and issues one per cycle to the combinational BJU through a registered execute stage. It captures link results for writeback, holds a taken redirect until the frontend accepts it, and squashes younger buffered ops on a redirect or an external pipeline flush.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
ROB_IDX_W, 6, width of ROB index tag
SRC_W, 64, operand/result width (matches SRC/RESULT range)
PC_W, 48, PC width (matches PC range)
CX_W, 6, cx_type one-hot width (bit0 JAL, 1 JALR, 2 BEQ, 3 BNE, 4 BLT/BLTU, 5 BGE/BGEU)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
flush_valid  in  1  pipeline flush from ROB
enq_valid  in  1  dispatch offers an op
enq_ready  out  1  controller accepts the op
enq_src1 / enq_src2 / enq_imm  in  SRC_W  operands, immediate
enq_pc  in  PC_W  instruction PC
enq_cx_type  in  CX_W  op select
enq_is_unsigned  in  1  unsigned compare
enq_robidx  in  ROB_IDX_W  ROB tag
bju_valid  out  1  execute-stage valid to BJU
bju_src1 / bju_src2 / bju_imm  out  SRC_W  registered operands to BJU
bju_pc  out  PC_W  registered PC
bju_cx_type  out  CX_W  registered op select
bju_is_unsigned  out  1  registered unsigned flag
bju_dest  in  SRC_W  BJU link result (pc+4)
bju_redirect_valid  in  1  BJU taken/jump
bju_redirect_target  in  PC_W  BJU target
wb_valid  out  1  one-cycle writeback pulse
wb_dest  out  SRC_W  link value
wb_robidx  out  ROB_IDX_W  tag of written-back op
redir_valid  out  1  redirect pending to frontend
redir_target  out  PC_W  redirect PC
redir_robidx  out  ROB_IDX_W  tag of redirecting op
redir_ready  in  1  frontend accepts redirect

Behaviour:
- Reset (reset_n=0 at a clock edge): FIFO empty, pointers 0, ex stage invalid, state RUN; bju_valid, wb_valid, redir_valid = 0; all data outputs 0.
- FIFO: ptr+wrap-bit scheme; full when count==DEPTH; enq_ready = (state==RUN) & ~full & ~flush_valid. Enqueue fires on enq_valid&enq_ready.
- Execute stage: loads FIFO head at every edge when FIFO non-empty and state==RUN and no redirect detected this cycle; otherwise ex goes invalid. BJU is combinational, so ex always completes in one cycle. bju_valid = ex valid.
- Latency: enq at edge t into empty FIFO -> bju_valid during cycle t+1 -> wb_valid during cycle t+2. Sustained throughput 1 op/cycle.
- Writeback: every completing ex op produces wb_valid=1 for one cycle with wb_dest=bju_dest, wb_robidx=ex tag, including branches (ROB ignores dest for B-type).
- FSM states RUN, REDIR_WAIT.
  RUN -> REDIR_WAIT when bju_valid & bju_redirect_valid: latch redir_target/redir_robidx, set redir_valid, clear FIFO (all entries are younger), do not load ex; an op enqueued in that same cycle is also dropped.
  REDIR_WAIT: enq_ready=0, no issue; redir_valid held stable with target/tag until redir_valid&redir_ready; then -> RUN, redir_valid=0 next cycle.
- flush_valid (highest priority, any state): next edge clears FIFO, ex valid, wb_valid, redir_valid; state RUN. A redirect coinciding with flush is discarded. An ex op in the flush cycle produces no writeback.
- Same-cycle redir_ready handshake and new redirect cannot coincide (no issue in REDIR_WAIT).
- Pointer wrap at DEPTH is silent; enqueue while full is impossible (enq_ready=0).

Test Plan:
- Reset then 3 non-taken BEQ (src1=1, src2=2, robidx 1,2,3) back-to-back -> wb_valid on 3 consecutive cycles, tags 1,2,3, redir_valid stays 0.
- JAL pc=0x1000 imm=0x20 followed by 2 queued ops, BJU returns target 0x1020 -> wb_dest=0x1004, redir_valid=1 target 0x1020; queued ops never issued; enq_ready=0 until redir_ready.
- Hold redir_ready=0 for 5 cycles -> redir_valid/target stable; raise redir_ready -> redir_valid=0 next cycle, enq_ready=1.
- Stall downstream by filling: enqueue 4 ops while forcing a pending redirect -> enq_ready=0; after handshake FIFO empty (count 0), new enq issues with 2-cycle latency.
- flush_valid during REDIR_WAIT with 2 ops queued -> next cycle redir_valid=0, FIFO empty, no wb_valid, state RUN.
- reset_n low mid-stream with bju_valid=1 -> next edge all valids 0, no writeback for the in-flight op.
